// File: rtl/hdmi_tg_pkg.sv
// Shared timing defaults, total derivation, sync polarity constants and helpers
// for the HDMI timing generator.
package hdmi_tg_pkg;

   localparam int CNT_W = 10;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_READ_LAT = 2;

   localparam int SYNC_POL_LOW  = 0;
   localparam int SYNC_POL_HIGH = 1;

   typedef enum logic {TG_IDLE, TG_RUN} tg_state_t;

   // Raw timing strobes carried together through the pixel delay line.
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } tg_sig_t;

   function automatic int tg_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   localparam int DEF_H_TOTAL = tg_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL = tg_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_color = 24'hFFFFFF;
         3'd1:    bar_color = 24'hFFFF00;
         3'd2:    bar_color = 24'h00FFFF;
         3'd3:    bar_color = 24'h00FF00;
         3'd4:    bar_color = 24'hFF00FF;
         3'd5:    bar_color = 24'hFF0000;
         3'd6:    bar_color = 24'h0000FF;
         default: bar_color = 24'h000000;
      endcase
   endfunction

endpackage

// File: rtl/tg_delay_line.sv
// Pixel-tick gated shift line: DEPTH stages of WIDTH bits, advancing only on en.
// DEPTH=0 is a straight wire.
module tg_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_thru
         logic unused_ctl;
         assign unused_ctl = ^{clk, rstn, en, clr};
         assign q = d;
      end else begin : g_shift
         logic [DEPTH-1:0][WIDTH-1:0] sr;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               sr <= '0;
            end else if (clr) begin
               sr <= '0;
            end else if (en) begin
               sr[0] <= d;
               for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
         end

         assign q = sr[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/hdmi_timing_gen.sv
// HDMI/DVI raster timing generator with pixel-tick delayed DE/sync.
// Define HDMI_TG_TESTPAT_EN to add the tp_data 8-bar colour pattern output.
module hdmi_timing_gen
   import hdmi_tg_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int SYNC_POL = SYNC_POL_LOW,
   parameter int READ_LAT = DEF_READ_LAT
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             pix_en,
   input  logic             run,
`ifdef HDMI_TG_TESTPAT_EN
   output logic [23:0]      tp_data,
`endif
   output logic             HVsync,
   output logic             HMemRead,
   output logic             pVDE,
   output logic             hsync,
   output logic             vsync,
   output logic             frame_start,
   output logic [CNT_W-1:0] pix_cnt,
   output logic [CNT_W-1:0] line_cnt
);

   localparam int H_TOTAL = tg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = tg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   tg_state_t        state, state_nxt;
   logic [CNT_W-1:0] hcnt, vcnt, h_nxt, v_nxt;
   logic             fs_nxt, fs_q;
   logic             hv_nxt, hv_q;
   logic             live;
   tg_sig_t          raw_nxt, raw_q, dly;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= TG_IDLE;
         hcnt  <= '0;
         vcnt  <= '0;
         fs_q  <= 1'b0;
         hv_q  <= 1'b0;
         raw_q <= '0;
      end else begin
         state <= state_nxt;
         hcnt  <= h_nxt;
         vcnt  <= v_nxt;
         fs_q  <= fs_nxt;
         hv_q  <= hv_nxt;
         raw_q <= raw_nxt;
      end
   end

   // The first tick after start only arms the raster at 0,0 and marks the frame.
   always_comb begin
      state_nxt = state;
      h_nxt     = hcnt;
      v_nxt     = vcnt;
      fs_nxt    = 1'b0;
      if (!run) begin
         state_nxt = TG_IDLE;
         h_nxt     = '0;
         v_nxt     = '0;
      end else if (pix_en) begin
         case (state)
            TG_IDLE: begin
               state_nxt = TG_RUN;
               h_nxt     = '0;
               v_nxt     = '0;
               fs_nxt    = 1'b1;
            end
            default: begin
               if (hcnt == H_LAST) begin
                  h_nxt = '0;
                  if (vcnt == V_LAST) begin
                     v_nxt  = '0;
                     fs_nxt = 1'b1;
                  end else begin
                     v_nxt = vcnt + CNT_W'(1);
                  end
               end else begin
                  h_nxt = hcnt + CNT_W'(1);
               end
            end
         endcase
      end
      live       = (state_nxt == TG_RUN);
      raw_nxt.de = live && (h_nxt < H_ACT) && (v_nxt < V_ACT);
      raw_nxt.hs = live && (h_nxt >= HS_BEG) && (h_nxt < HS_END);
      raw_nxt.vs = live && (v_nxt >= VS_BEG) && (v_nxt < VS_END);
      hv_nxt     = live && (v_nxt < V_ACT);
   end

   tg_delay_line #(.WIDTH($bits(tg_sig_t)), .DEPTH(READ_LAT)) u_sig_dly (
      .clk  (clk),
      .rstn (rstn),
      .en   (pix_en & run),
      .clr  (~run),
      .d    (raw_q),
      .q    (dly)
   );

   assign HMemRead    = raw_q.de;
   assign HVsync      = hv_q;
   assign frame_start = fs_q;
   assign pVDE        = dly.de;
   assign hsync       = (SYNC_POL != 0) ? dly.hs : ~dly.hs;
   assign vsync       = (SYNC_POL != 0) ? dly.vs : ~dly.vs;
   assign pix_cnt     = hcnt;
   assign line_cnt    = vcnt;

`ifdef HDMI_TG_TESTPAT_EN
   logic [2:0] bar_nxt, bar_q, bar_d;

   always_comb begin
      bar_nxt = '0;
      if (raw_nxt.de) bar_nxt = 3'((32'(h_nxt) * 32'd8) / 32'(H_ACTIVE));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) bar_q <= '0;
      else       bar_q <= bar_nxt;
   end

   tg_delay_line #(.WIDTH(3), .DEPTH(READ_LAT)) u_bar_dly (
      .clk  (clk),
      .rstn (rstn),
      .en   (pix_en & run),
      .clr  (~run),
      .d    (bar_q),
      .q    (bar_d)
   );

   assign tp_data = dly.de ? bar_color(bar_d) : 24'h000000;
`endif

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Randomized bench for hdmi_timing_gen: two instances (latency 2 / active-low,
// latency 0 / active-high) against a raster model indexed by pixel-tick count.
module tb_hdmi_timing_gen;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic clk = 1'b0, rstn = 1'b0, pix_en = 1'b0, run = 1'b0;
   logic hv0, mr0, de0, hs0, vs0, fs0, hv1, mr1, de1, hs1, vs1, fs1;
   logic [9:0] pc0, lc0, pc1, lc1;
`ifdef HDMI_TG_TESTPAT_EN
   logic [23:0] tp0, tp1;
`endif

   hdmi_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .SYNC_POL(0), .READ_LAT(2)) u_dut0 (
      .clk(clk), .rstn(rstn), .pix_en(pix_en), .run(run),
`ifdef HDMI_TG_TESTPAT_EN
      .tp_data(tp0),
`endif
      .HVsync(hv0), .HMemRead(mr0), .pVDE(de0), .hsync(hs0), .vsync(vs0),
      .frame_start(fs0), .pix_cnt(pc0), .line_cnt(lc0));

   hdmi_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .SYNC_POL(1), .READ_LAT(0)) u_dut1 (
      .clk(clk), .rstn(rstn), .pix_en(pix_en), .run(run),
`ifdef HDMI_TG_TESTPAT_EN
      .tp_data(tp1),
`endif
      .HVsync(hv1), .HMemRead(mr1), .pVDE(de1), .hsync(hs1), .vsync(vs1),
      .frame_start(fs1), .pix_cnt(pc1), .line_cnt(lc1));

   always #5 clk = ~clk;

   int     n_chk = 0, n_err = 0;
   longint m_t = -1;   // pixel ticks since the raster started, -1 when idle
   bit     m_fs = 1'b0;
   longint cyc = 0;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit de_at(input longint t);
      if (t < 0) return 1'b0;
      return ((t % HT) < HA) && (((t / HT) % VT) < VA);
   endfunction

   function automatic bit hs_at(input longint t);
      if (t < 0) return 1'b0;
      return ((t % HT) >= HA + HF) && ((t % HT) < HA + HF + HS);
   endfunction

   function automatic bit vs_at(input longint t);
      if (t < 0) return 1'b0;
      return (((t / HT) % VT) >= VA + VF) && (((t / HT) % VT) < VA + VF + VS);
   endfunction

   function automatic logic [23:0] tp_at(input longint t);
      if (!de_at(t)) return 24'h0;
      return bars[((t % HT) * 8) / HA];
   endfunction

   task automatic check_dut(input string id, input int lat, input int pol,
                            input logic hv, input logic mr, input logic de,
                            input logic hs, input logic vs, input logic fs,
                            input logic [9:0] pc, input logic [9:0] lc);
      longint d = m_t - lat;
      chk({id, ".HMemRead"},    32'(mr), 32'(de_at(m_t)));
      chk({id, ".HVsync"},      32'(hv), 32'(m_t >= 0 && ((m_t / HT) % VT) < VA));
      chk({id, ".pVDE"},        32'(de), 32'(de_at(d)));
      chk({id, ".hsync"},       32'(hs), 32'((pol != 0) ? hs_at(d) : !hs_at(d)));
      chk({id, ".vsync"},       32'(vs), 32'((pol != 0) ? vs_at(d) : !vs_at(d)));
      chk({id, ".frame_start"}, 32'(fs), 32'(m_fs));
      chk({id, ".pix_cnt"},     32'(pc), (m_t < 0) ? 32'd0 : 32'(m_t % HT));
      chk({id, ".line_cnt"},    32'(lc), (m_t < 0) ? 32'd0 : 32'((m_t / HT) % VT));
   endtask

   task automatic check_all();
      check_dut("d0", 2, 0, hv0, mr0, de0, hs0, vs0, fs0, pc0, lc0);
      check_dut("d1", 0, 1, hv1, mr1, de1, hs1, vs1, fs1, pc1, lc1);
`ifdef HDMI_TG_TESTPAT_EN
      chk("d0.tp_data", 32'(tp0), 32'(tp_at(m_t - 2)));
      chk("d1.tp_data", 32'(tp1), 32'(tp_at(m_t)));
`endif
   endtask

   // Drive inputs, take one clock edge, advance the model, check #1 later.
   task automatic step(input bit pe, input bit r);
      pix_en = pe;
      run    = r;
      @(posedge clk);
      cyc++;
      m_fs = 1'b0;
      if (!rstn || !r) begin
         m_t = -1;
      end else if (pe) begin
         m_t++;
         m_fs = (m_t % FRAME) == 0;
      end
      #1;
      check_all();
   endtask

   initial begin
      longint last_fs;
      bit     r;
      int     guard;

      // Reset state
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      rstn = 1'b1;

      // Two frames with a tick every 5 clk; frame_start spacing
      last_fs = -1;
      for (int i = 0; i < 2 * FRAME * 5 + 20; i++) begin
         step(i % 5 == 0, 1'b1);
         if (fs0) begin
            if (last_fs >= 0) chk("fs_spacing", 32'(cyc - last_fs), 32'(FRAME * 5));
            last_fs = cyc;
         end
      end

      // Random ticks with occasional run drops
      r = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         if (r && $urandom_range(0, 399) == 0) r = 1'b0;
         else if (!r && $urandom_range(0, 19) == 0) r = 1'b1;
         step($urandom_range(0, 2) == 0, r);
      end

      // Drop run mid-frame at line 3 pixel 10, ignore ticks, then restart
      guard = 0;
      while (!(m_t >= 0 && (m_t % FRAME) == 3 * HT + 10) && guard < 5000) begin
         step($urandom_range(0, 1) == 0, 1'b1);
         guard++;
      end
      chk("drop_point_reached", 32'(guard < 5000), 32'd1);
      step(1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      chk("restart_frame_start", 32'(fs1), 32'd1);
      for (int i = 0; i < 300; i++) step($urandom_range(0, 1) == 0, 1'b1);

      // Asynchronous reset mid-line
      guard = 0;
      while (!(m_t >= 0 && (m_t % HT) == 5) && guard < 1000) begin
         step(1'b1, 1'b1);
         guard++;
      end
      chk("reset_point_reached", 32'(guard < 1000), 32'd1);
      #1 rstn = 1'b0;
      #1;
      m_t  = -1;
      m_fs = 1'b0;
      check_all();
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      rstn = 1'b1;
      for (int i = 0; i < 2000; i++) step($urandom_range(0, 3) == 0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/hdmi_timing_gen.md
HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48: front porch, sync width and back porch, in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: the same quantities in lines.
REQ-004 SHALL have parameter SYNC_POL, default 0; 0 means hsync/vsync are active-low.
REQ-005 SHALL have parameter READ_LAT, default 2, range 0..7: pixel ticks from HMemRead to pVDE.
REQ-006 clk  input  1  system clock.
REQ-007 rstn  input  1  reset, asynchronous, active-low.
REQ-008 pix_en  input  1  one-clk pixel tick; one tick every 5 clk in system use.
REQ-009 run  input  1  timing enable; low holds the generator idle.
REQ-010 HVsync  output  1  high during active lines; low during vertical blanking, which restarts the receiver read address.
REQ-011 HMemRead  output  1  memory read window, leads pVDE.
REQ-012 pVDE  output  1  video data enable to HDMI encoder.
REQ-013 hsync, vsync  output  1 each  sync pulses, polarity per SYNC_POL.
REQ-014 frame_start  output  1  one-clk pulse at the start of each frame.
REQ-015 pix_cnt, line_cnt  output  10 each  current hcnt/vcnt.

Function
REQ-016 hcnt SHALL advance only on clk edges where pix_en=1 and run=1.
REQ-017 hcnt SHALL wrap to 0 after H_TOTAL-1 (H_TOTAL = 800 at defaults).
REQ-018 vcnt SHALL increment on each hcnt wrap and wrap to 0 after V_TOTAL-1 (V_TOTAL = 525 at defaults).
REQ-019 HMemRead SHALL be registered and high iff hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-020 HVsync SHALL be registered and high iff vcnt<V_ACTIVE.
REQ-021 Raw DE SHALL be high iff hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-022 Raw hsync SHALL be asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
REQ-023 Raw vsync SHALL be asserted for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-024 pVDE, hsync and vsync SHALL be the raw signals delayed by READ_LAT pix_en ticks through a shift line that advances only on pix_en.
REQ-025 With READ_LAT=0, pVDE SHALL equal HMemRead cycle-for-cycle.
REQ-026 frame_start SHALL pulse for exactly one clk on the pix_en tick where hcnt and vcnt both become 0.
REQ-027 run falling SHALL clear hcnt, vcnt and the delay line on the next clk; all outputs go inactive, with hsync/vsync at their deasserted level.
REQ-028 run rising SHALL start counting from hcnt=0, vcnt=0 at the next pix_en.
REQ-029 The first pix_en after run rises SHALL produce frame_start.
REQ-030 pix_en with run=0 SHALL be ignored.

Reset
REQ-031 While rstn=0 SHALL hold hcnt=vcnt=0, delay line cleared, HVsync=HMemRead=pVDE=frame_start=0, and hsync=vsync=~SYNC_POL.
REQ-032 Reset asserted mid-frame SHALL abort immediately; after rstn rises, timing SHALL restart from line 0, pixel 0.

Configuration
REQ-033 Macro HDMI_TG_TESTPAT_EN defined SHALL add output tp_data[23:0] carrying an 8-bar colour pattern.
REQ-034 Bar order: white, yellow, cyan, green, magenta, red, blue, black; bar index = hcnt*8/H_ACTIVE; value delayed to align with pVDE.
REQ-035 tp_data SHALL be 0 when pVDE=0.
REQ-036 Macro undefined SHALL leave tp_data absent with no pattern logic.

Structure
REQ-037 Default timing constants, H_TOTAL/V_TOTAL derivation and sync-polarity constants SHALL live in shared package hdmi_tg_pkg.
REQ-038 One sub-module tg_delay_line SHALL implement the parameterised pix_en-gated shift line (width, depth).

Verification
REQ-039 Defaults, pix_en every 5 clk, 2 frames -> 420000 pix_en per frame; frame_start pulses spaced 2100000 clk.
REQ-040 Per active line -> HMemRead high 640 ticks, pVDE rises exactly 2 ticks after HMemRead; hsync low 96 ticks starting at hcnt=656.
REQ-041 Per frame -> vsync low on lines 490-491; HVsync low for lines 480-524.
REQ-042 run dropped at vcnt=200, hcnt=300, raised later -> outputs idle next clk, then frame_start on first pix_en.
REQ-043 rstn pulsed mid-line, READ_LAT=0 -> outputs at reset values; after release pVDE==HMemRead on every clk.
REQ-044 HDMI_TG_TESTPAT_EN defined -> tp_data=24'hFFFFFF for pixels 0-79, 24'h0000FF for pixels 480-559 (blue), 0 when pVDE=0.
